// File: rtl/sobel_stream_if.sv
// sobel_stream_if: pixel-stream bundle for sobel_stream.
//   in_valid/in_sof/in_pix : raster-order input stream. There is no
//                            backpressure, so a pixel is accepted on every
//                            cycle with in_valid=1. in_sof is only meaningful
//                            while in_valid=1.
//   mode/thresh            : per-frame configuration, sampled with the in_sof
//                            pixel.
//   out_valid/out_pix      : edge stream. out_pix is meaningful only while
//                            out_valid=1.
//   frame_done             : one-cycle pulse with the last output of a frame.
// master = pixel source / sink side, slave = the engine.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pix;
  logic [1:0]       mode;
  logic [PIX_W-1:0] thresh;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic             frame_done;

  modport master (
    output in_valid, in_sof, in_pix, mode, thresh,
    input  out_valid, out_pix, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pix, mode, thresh,
    output out_valid, out_pix, frame_done
  );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector.
// Builds the 3x3 neighbourhood from two line buffers and a shifting window,
// then computes the gradients in a 4-stage pipeline:
//   S1 window / line-buffer update, S2 gx/gy, S3 |gx|,|gy|,sum,
//   S4 mode select and saturation into out_pix.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sobel_stream_if.slave (input stream, config, output stream)
// One output is produced for each accepted pixel at row>=2, col>=2, three
// clocks after the accepting edge.
module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  sobel_stream_if.slave  bus
);
  localparam int GW = PIX_W + 3;  // signed gradient / sum width
  localparam int AW = PIX_W + 2;  // absolute gradient width
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  logic             accept;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [1:0]       mode_q, mode_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] win_q [9];

  // Mode and threshold travel with each window so that outputs still in
  // flight when a new frame starts keep the configuration of their own frame.
  logic             s1_v_q, s1_last_q, s2_v_q, s2_last_q, s3_v_q, s3_last_q;
  logic [1:0]       s1_mode_q, s2_mode_q, s3_mode_q;
  logic [PIX_W-1:0] s1_thr_q, s2_thr_q, s3_thr_q;

  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
  logic [AW-1:0]        agx_c, agy_c, agx_q, agy_q;
  logic [GW-1:0]        sum_c, sum_q;
  logic [PIX_W-1:0]     out_c, out_pix_q;
  logic                 out_valid_q, frame_done_q;

  function automatic logic signed [GW-1:0] zx(input logic [PIX_W-1:0] p);
    return $signed({{(GW-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
    return (|v[GW-1:PIX_W]) ? '1 : v[PIX_W-1:0];
  endfunction

  assign accept = bus.in_valid;

  // An in_sof pixel is treated as (0,0) for line-buffer addressing, window
  // gating and counter advance alike.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    lb1_rd  = lb1_q[cur_col];
    lb2_rd  = lb2_q[cur_col];
    mode_d  = (accept && bus.in_sof) ? bus.mode   : mode_q;
    thr_d   = (accept && bus.in_sof) ? bus.thresh : thr_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // Line buffers are not reset; row>=2 gating keeps stale lines unused.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[cur_col] <= bus.in_pix;
      lb2_q[cur_col] <= lb1_rd;
    end
  end

  // S1: counters, configuration and window shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 2'b00;
      thr_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_mode_q <= 2'b00;
      s1_thr_q  <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      thr_q  <= thr_d;
      s1_v_q <= accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      if (accept) begin
        s1_last_q <= (cur_row == LAST_ROW) && (cur_col == LAST_COL);
        s1_mode_q <= mode_d;
        s1_thr_q  <= thr_d;
        win_q[0]  <= win_q[1];
        win_q[1]  <= win_q[2];
        win_q[2]  <= lb2_rd;
        win_q[3]  <= win_q[4];
        win_q[4]  <= win_q[5];
        win_q[5]  <= lb1_rd;
        win_q[6]  <= win_q[7];
        win_q[7]  <= win_q[8];
        win_q[8]  <= bus.in_pix;
      end
    end
  end

  assign gx_c = (zx(win_q[2]) + (zx(win_q[5]) <<< 1) + zx(win_q[8]))
              - (zx(win_q[0]) + (zx(win_q[3]) <<< 1) + zx(win_q[6]));
  assign gy_c = (zx(win_q[0]) + (zx(win_q[1]) <<< 1) + zx(win_q[2]))
              - (zx(win_q[6]) + (zx(win_q[7]) <<< 1) + zx(win_q[8]));

  // |g| <= 4*(2^PIX_W-1), so the top (sign) bit is always dropped safely.
  always_comb begin
    agx_c = AW'(gx_q[GW-1] ? -gx_q : gx_q);
    agy_c = AW'(gy_q[GW-1] ? -gy_q : gy_q);
    sum_c = {1'b0, agx_c} + {1'b0, agy_c};
  end

  always_comb begin
    out_c = '0;
    case (s3_mode_q)
      2'b00:   out_c = sat(sum_q);
      2'b01:   out_c = sat({1'b0, agx_q});
      2'b10:   out_c = sat({1'b0, agy_q});
      default: out_c = (sum_q >= {{(GW-PIX_W){1'b0}}, s3_thr_q}) ? '1 : '0;
    endcase
  end

  // S2..S4: data registers load only with a valid window, so out_pix holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q       <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_mode_q    <= 2'b00;
      s2_thr_q     <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      s3_v_q       <= 1'b0;
      s3_last_q    <= 1'b0;
      s3_mode_q    <= 2'b00;
      s3_thr_q     <= '0;
      agx_q        <= '0;
      agy_q        <= '0;
      sum_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_pix_q    <= '0;
    end else begin
      s2_v_q       <= s1_v_q;
      s3_v_q       <= s2_v_q;
      out_valid_q  <= s3_v_q;
      frame_done_q <= s3_v_q && s3_last_q;
      if (s1_v_q) begin
        s2_last_q <= s1_last_q;
        s2_mode_q <= s1_mode_q;
        s2_thr_q  <= s1_thr_q;
        gx_q      <= gx_c;
        gy_q      <= gy_c;
      end
      if (s2_v_q) begin
        s3_last_q <= s2_last_q;
        s3_mode_q <= s2_mode_q;
        s3_thr_q  <= s2_thr_q;
        agx_q     <= agx_c;
        agy_q     <= agy_c;
        sum_q     <= sum_c;
      end
      if (s3_v_q) out_pix_q <= out_c;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pix    = out_pix_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised 3x3 Sobel edge-detection engine. Accepts a raster-order pixel stream, builds the 3x3 neighbourhood internally with two line buffers and a window register, computes both gradients in a pipeline and emits one edge pixel per interior image position. It sits between the pixel source (camera or frame reader) and the downstream filter or frame writer, and replaces per-pixel combinational gradient blocks that need an external window.

## Interface
- PIX_W, 8: pixel width in bits.
- IMG_W, 640: pixels per line; line-buffer depth.
- IMG_H, 480: lines per frame.
- COL_W, 10: column counter width; must satisfy 2^COL_W >= IMG_W.
- ROW_W, 9: row counter width; must satisfy 2^ROW_W >= IMG_H.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pix is valid this cycle; there is no backpressure.
- in_sof  in  1  marks the first pixel of a frame; qualified by in_valid.
- in_pix  in  PIX_W  input pixel, unsigned.
- mode  in  2  00 = |gx|+|gy|, 01 = |gx|, 10 = |gy|, 11 = binary threshold on |gx|+|gy|.
- thresh  in  PIX_W  threshold for mode 11.
- out_valid  out  1  out_pix is valid.
- out_pix  out  PIX_W  edge pixel, unsigned.
- frame_done  out  1  one-cycle pulse together with the last output of a frame.

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel (in_valid=1). col wraps to 0 and row increments at IMG_W-1. Both wrap to 0 after (IMG_W-1, IMG_H-1).
- in_sof with in_valid forces that pixel to (0,0), even mid-frame. mode and thresh are latched at that pixel and held for the whole frame.
- Line buffers: LB1 holds row-1 and LB2 holds row-2, both indexed by col. Reads and writes share the same col. The write of LB2 takes LB1's old data.
- The window shifts left on each accept. The new right column is {LB2[col], LB1[col], in_pix}, with the top row first. Naming the window p0..p8 in row-major order, p0 is the top-left and p8 is the bottom-right (the current pixel).
- A window is valid when row>=2 and col>=2. Its centre is (row-1, col-1). Each frame produces exactly (IMG_W-2)*(IMG_H-2) outputs. Border pixels produce no output.
- Gradients:
  - gx = (p2+2p5+p8)-(p0+2p3+p6)
  - gy = (p0+2p1+p2)-(p6+2p7+p8)
  - Both are signed, PIX_W+3 bits wide, and cannot overflow.
- Absolute values are PIX_W+2 bits unsigned. The sum is PIX_W+3 bits.
- Output value by mode:
  - 00: sum, saturated to 2^PIX_W-1.
  - 01: |gx|, saturated.
  - 10: |gy|, saturated.
  - 11: all-ones if sum >= thresh (zero-extended), else 0.
- frame_done asserts with the output whose window is at bottom-right position (IMG_H-1, IMG_W-1).
- Line-buffer contents are not cleared at a new frame. The row>=2 gating guarantees that stale data is never used.

## Timing
- Pipeline, with k the edge that accepts the pixel:
  - S1 at edge k: window and line-buffer update.
  - S2 at edge k+1: gx and gy registered.
  - S3 at edge k+2: |gx|, |gy| and sum registered.
  - S4 at edge k+3: mode select and saturation, registered into out_pix.
- Latency is 3 clocks from the accepting edge to out_valid high. Throughput is 1 pixel per clock.
- A valid bit travels alongside the data. Input bubbles (in_valid=0) freeze the counters, window and line buffers, and appear as out_valid=0 gaps with the same spacing.
- in_sof mid-frame does not flush data already in S2–S4. Those outputs still emerge, after which the new frame starts.
- Reset clears: out_valid=0, out_pix=0, frame_done=0, all pipeline valid bits, col=0, row=0, the window, mode=00 and thresh=0. Line-buffer RAM is not reset.
- Reset mid-frame discards everything in flight. The next frame must begin with in_sof.
- out_pix holds its last value while out_valid=0.

## Test plan
Parameters for all scenarios: PIX_W=8, IMG_W=8, IMG_H=6.

- Flat frame of 100s, mode 00, continuous in_valid → exactly 24 outputs, all 0. frame_done pulses once with the 24th output. The first output appears 3 clocks after accepting pixel (2,2).
- Vertical step (cols 0–3 = 0, cols 4–7 = 255):
  - mode 00: 255 at centre cols 3–4, 0 elsewhere.
  - mode 01: same as mode 00.
  - mode 10: all 0.
  - Internal gx at centre col 3 = +1020.
- Horizontal step (rows 0–2 = 0, rows 3–5 = 40), mode 10: centre rows 2–3 give |gy| = 160, all other outputs 0. Mode 11 with thresh=161 gives all 0; with thresh=160 gives 255 on those rows.
- Random in_valid (50% duty) with random pixels → the output sequence matches the software model, out_valid gaps mirror the input gaps, and the output count is 24.
- in_sof reasserted at pixel 20 of frame 1, followed by a full frame 2 → the in-flight outputs of frame 1 drain, and frame 2 gives 24 correct outputs with mode and thresh latched at its in_sof.
- rst_n pulsed low mid-frame → out_valid and frame_done drop asynchronously, and out_pix=0. The following frame, started with in_sof, produces 24 correct outputs.
